// File: rtl/hc194_universal_shift.sv
// WIDTH-bit 74HC194-style universal shift register with complementary outputs.
// Optional rotate select port p13 enabled by defining HC194_ROTATE_EN.
module hc194_universal_shift #(
    parameter int               WIDTH       = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             p2,
    input  logic             p1,
    input  logic             p3,
    input  logic             p4,
    input  logic             p5,
    input  logic             p6,
    input  logic             p7,
    input  logic [WIDTH-1:0] p8,
    output logic [WIDTH-1:0] p9,
    output logic [WIDTH-1:0] p10,
    output logic             p11,
    output logic             p12
`ifdef HC194_ROTATE_EN
    ,
    input  logic             p13
`endif
);

    logic [WIDTH-1:0] q_q  = RESET_VALUE;
    logic [WIDTH-1:0] qn_q = ~RESET_VALUE;
    logic [WIDTH-1:0] q_d;
    logic             sr_in;
    logic             sl_in;

`ifdef HC194_ROTATE_EN
    assign sr_in = p13 ? q_q[WIDTH-1] : p6;
    assign sl_in = p13 ? q_q[0] : p7;
`else
    assign sr_in = p6;
    assign sl_in = p7;
`endif

    // Unknown mode bits fall through to the hold default.
    always_comb begin
        q_d = q_q;
        if (p3) begin
            case ({p5, p4})
                2'b01:   q_d = {q_q[WIDTH-2:0], sr_in};
                2'b10:   q_d = {sl_in, q_q[WIDTH-1:1]};
                2'b11:   q_d = p8;
                default: q_d = q_q;
            endcase
        end
    end

    always_ff @(posedge p2) begin
        if (p1) begin
            q_q  <= RESET_VALUE;
            qn_q <= ~RESET_VALUE;
        end else begin
            q_q  <= q_d;
            qn_q <= ~q_d;
        end
    end

    assign p9  = q_q;
    assign p10 = qn_q;
    assign p11 = q_q[WIDTH-1];
    assign p12 = q_q[0];

endmodule

// File: tb/tb_hc194_universal_shift.sv
// Directed scoreboard bench for hc194_universal_shift (WIDTH=4, RESET_VALUE=1010).
// Rotate steps are built only when HC194_ROTATE_EN is defined.
module tb_hc194_universal_shift;

    localparam int         W  = 4;
    localparam logic [3:0] RV = 4'b1010;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         ce  = 1'b0;
    logic         s0  = 1'b0;
    logic         s1  = 1'b0;
    logic         dsr = 1'b0;
    logic         dsl = 1'b0;
    logic [W-1:0] d   = '0;
    logic [W-1:0] q;
    logic [W-1:0] qn;
    logic         sor;
    logic         sol;
`ifdef HC194_ROTATE_EN
    logic         rot = 1'b0;
`endif

    typedef struct {
        logic [W-1:0] q;
        string        tag;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] model_q = RV;
    int           n_cmp = 0;
    int           n_bad = 0;

    hc194_universal_shift #(.WIDTH(W), .RESET_VALUE(RV)) dut (
        .p2  (clk),
        .p1  (rst),
        .p3  (ce),
        .p4  (s0),
        .p5  (s1),
        .p6  (dsr),
        .p7  (dsl),
        .p8  (d),
        .p9  (q),
        .p10 (qn),
        .p11 (sor),
        .p12 (sol)
`ifdef HC194_ROTATE_EN
        ,
        .p13 (rot)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] model_next(
        input logic [W-1:0] cur,
        input logic         r,
        input logic         e,
        input logic         m0,
        input logic         m1,
        input logic         sr,
        input logic         sl,
        input logic [W-1:0] pd,
        input logic         ro
    );
        logic [W-1:0] n;
        n = cur;
        if (r === 1'b1) n = RV;
        else if (e === 1'b1) begin
            if (m1 === 1'b0 && m0 === 1'b1)
                for (int i = 0; i < W; i++)
                    n[i] = (i == 0) ? (ro ? cur[W-1] : sr) : cur[i-1];
            else if (m1 === 1'b1 && m0 === 1'b0)
                for (int i = 0; i < W; i++)
                    n[i] = (i == W-1) ? (ro ? cur[0] : sl) : cur[i+1];
            else if (m1 === 1'b1 && m0 === 1'b1)
                n = pd;
        end
        return n;
    endfunction

    task automatic check_outputs(input logic [W-1:0] e, input string tag);
        n_cmp++;
        assert (q === e) else begin
            n_bad++;
            $error("FAIL %s.q observed=%b expected=%b", tag, q, e);
        end
        n_cmp++;
        assert (qn === ~e) else begin
            n_bad++;
            $error("FAIL %s.qn observed=%b expected=%b", tag, qn, ~e);
        end
        n_cmp++;
        assert (sor === e[W-1]) else begin
            n_bad++;
            $error("FAIL %s.sor observed=%b expected=%b", tag, sor, e[W-1]);
        end
        n_cmp++;
        assert (sol === e[0]) else begin
            n_bad++;
            $error("FAIL %s.sol observed=%b expected=%b", tag, sol, e[0]);
        end
    endtask

    task automatic pop_and_check();
        exp_t x;
        n_cmp++;
        assert (sb.size() > 0) else begin
            n_bad++;
            $error("FAIL scoreboard observed=empty expected=entry");
            return;
        end
        x = sb.pop_front();
        check_outputs(x.q, x.tag);
    endtask

    task automatic step(
        input logic         r,
        input logic         e,
        input logic         m0,
        input logic         m1,
        input logic         sr,
        input logic         sl,
        input logic [W-1:0] pd,
        input logic         ro,
        input string        tag
    );
        exp_t x;
        @(negedge clk);
        rst = r; ce = e; s0 = m0; s1 = m1;
        dsr = sr; dsl = sl; d = pd;
`ifdef HC194_ROTATE_EN
        rot = ro;
`endif
        model_q = model_next(model_q, r, e, m0, m1, sr, sl, pd, ro);
        x.q = model_q; x.tag = tag;
        sb.push_back(x);
        @(posedge clk);
        #1;
        pop_and_check();
    endtask

    initial begin
        exp_t x;
        #1;
        check_outputs(RV, "powerup");

        step(1, 0, 0, 0, 0, 0, 4'h0, 0, "reset");
        check_outputs(4'b1010, "reset_const");

        // short reset pulse entirely between edges
        @(negedge clk);
        ce = 0;
        rst = 1;
        #2 rst = 0;
        x.q = model_q; x.tag = "rst_glitch";
        sb.push_back(x);
        @(posedge clk);
        #1;
        pop_and_check();

        step(0, 1, 1, 1, 0, 0, 4'b0110, 0, "load");
        check_outputs(4'b0110, "load_const");
        for (int i = 0; i < 3; i++)
            step(0, 0, 1, 0, 1, 1, 4'hF, 0, "ce_hold");
        step(0, 1, 0, 0, 1, 1, 4'hF, 0, "mode_hold");
        step(0, 1, 1'bx, 1'bx, 1, 1, 4'hF, 0, "mode_x");

        step(0, 1, 1, 0, 1, 0, 4'h0, 0, "shr1");
        check_outputs(4'b1101, "shr1_const");
        step(0, 1, 1, 0, 1, 0, 4'h0, 0, "shr2");
        check_outputs(4'b1011, "shr2_const");

        for (int i = 0; i < 4; i++)
            step(0, 1, 0, 1, 1, 0, 4'h0, 0, "shl");
        check_outputs(4'b0000, "shl_const");

        step(0, 1, 0, 1, 0, 1, 4'h0, 0, "shl_in1");
        step(0, 1, 1, 0, 0, 0, 4'h0, 0, "shr_in0");

        step(1, 1, 1, 1, 0, 0, 4'b1111, 0, "rst_wins");
        check_outputs(RV, "rst_wins_const");
        step(0, 1, 1, 1, 0, 0, 4'b1111, 0, "load_ff");
        check_outputs(4'b1111, "load_ff_const");

        step(0, 1, 1, 0, 0, 0, 4'h0, 0, "mix_shr");
        step(0, 1, 1, 1, 0, 0, 4'b1001, 0, "mix_load");
        step(0, 1, 0, 1, 0, 1, 4'h0, 0, "mix_shl");

`ifdef HC194_ROTATE_EN
        step(0, 1, 1, 1, 0, 0, 4'b1000, 0, "rot_load");
        for (int i = 0; i < 4; i++)
            step(0, 1, 1, 0, 0, 0, 4'h0, 1, "rotr");
        check_outputs(4'b1000, "rotr_const");
        for (int i = 0; i < 4; i++)
            step(0, 1, 0, 1, 1, 1, 4'h0, 1, "rotl");
        step(0, 1, 1, 0, 1, 1, 4'h0, 0, "rot_off");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
